fim_resync_bus: RTL and testbench



---
 rtl/fim_resync_bus_pkg.sv | 13 +
 rtl/fim_resync_bit.sv | 46 ++++
 rtl/fim_resync_bus.sv | 42 ++++
 tb/tb_fim_resync_bus.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fim_resync_bus_pkg.sv
// Shared constants and helpers for the multi-bit resync bus.
package fim_resync_bus_pkg;

  // Shortest chain that still gives a metastable first stage a full
  // period to resolve before anything downstream sees it.
  localparam int MIN_SYNC_LEN = 2;

  // Effective chain length: requested length, clamped to the minimum.
  function automatic int sync_len_eff(input int req_len);
    return (req_len < MIN_SYNC_LEN) ? MIN_SYNC_LEN : req_len;
  endfunction

endpackage

// File: rtl/fim_resync_bit.sv
// Single-bit LEN-stage flop synchronizer with a synchronous reset value.
// With NO_CUT=0 the first stage is a separately named register that carries
// synchronizer/false-path attributes, so CDC timing analysis can find it.
// Both flavours behave identically cycle for cycle.
module fim_resync_bit #(
  parameter int LEN        = 2,
  parameter bit INIT_VALUE = 1'b0,
  parameter bit NO_CUT     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (NO_CUT) begin : g_plain
    logic [LEN-1:0] chain;

    // Plain shift chain: stage 0 samples d, each later stage copies the previous one.
    always_ff @(posedge clk) begin
      if (reset) chain <= {LEN{INIT_VALUE}};
      else       chain <= {chain[LEN-2:0], d};
    end

    assign q = chain[LEN-1];
  end else begin : g_cut
    (* async_reg = "true", dont_touch = "true", altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic           meta;
    logic [LEN-2:0] tail;

    // First stage captures the asynchronous input; tail stages let it settle.
    always_ff @(posedge clk) begin
      if (reset) begin
        meta <= INIT_VALUE;
        tail <= {(LEN-1){INIT_VALUE}};
      end else begin
        meta    <= d;
        tail[0] <= meta;
        for (int k = 1; k < LEN-1; k++) tail[k] <= tail[k-1];
      end
    end

    assign q = tail[LEN-2];
  end

endmodule

// File: rtl/fim_resync_bus.sv
// Multi-bit flop synchronizer: WIDTH independent single-bit chains.
// No coherency between bits; multi-bit sources must be quasi-static or
// gray-coded so that per-bit skew of one cycle is harmless.
module fim_resync_bus
  import fim_resync_bus_pkg::*;
#(
  parameter int SYNC_CHAIN_LENGTH = 2,
  parameter int WIDTH             = 1,
  parameter int INIT_VALUE        = 0,
  parameter int NO_CUT            = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int SYNC_LEN_EFF = sync_len_eff(SYNC_CHAIN_LENGTH);
  localparam bit INIT_BIT     = (INIT_VALUE != 0);
  localparam bit NO_CUT_BIT   = (NO_CUT != 0);

  if (WIDTH < 1) begin : g_bad_width
    $error("fim_resync_bus: WIDTH must be at least 1");
  end
  if (INIT_VALUE != 0 && INIT_VALUE != 1) begin : g_bad_init
    $error("fim_resync_bus: INIT_VALUE must be 0 or 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fim_resync_bit #(
      .LEN       (SYNC_LEN_EFF),
      .INIT_VALUE(INIT_BIT),
      .NO_CUT    (NO_CUT_BIT)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .d    (d[i]),
      .q    (q[i])
    );
  end

endmodule

// File: tb/tb_fim_resync_bus.sv
// Directed bench for fim_resync_bus covering several parameter sets.
module tb_fim_resync_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: WIDTH=33, L=3, INIT=0
  logic        rst_a;
  logic [32:0] d_a, q_a;
  // B: WIDTH=8, L=2, INIT=1
  logic        rst_b;
  logic [7:0]  d_b, q_b;
  // C: WIDTH=4, requested L=1 (clamped to 2)
  logic        rst_c;
  logic [3:0]  d_c, q_c;
  // D/E: WIDTH=16, L=4, NO_CUT=1 vs NO_CUT=0
  logic        rst_d;
  logic [15:0] d_d, q_d, q_e;

  fim_resync_bus #(.SYNC_CHAIN_LENGTH(3), .WIDTH(33), .INIT_VALUE(0), .NO_CUT(1))
    dut_a (.clk(clk), .reset(rst_a), .d(d_a), .q(q_a));
  fim_resync_bus #(.SYNC_CHAIN_LENGTH(2), .WIDTH(8), .INIT_VALUE(1), .NO_CUT(1))
    dut_b (.clk(clk), .reset(rst_b), .d(d_b), .q(q_b));
  fim_resync_bus #(.SYNC_CHAIN_LENGTH(1), .WIDTH(4), .INIT_VALUE(0), .NO_CUT(1))
    dut_c (.clk(clk), .reset(rst_c), .d(d_c), .q(q_c));
  fim_resync_bus #(.SYNC_CHAIN_LENGTH(4), .WIDTH(16), .INIT_VALUE(0), .NO_CUT(1))
    dut_d (.clk(clk), .reset(rst_d), .d(d_d), .q(q_d));
  fim_resync_bus #(.SYNC_CHAIN_LENGTH(4), .WIDTH(16), .INIT_VALUE(0), .NO_CUT(0))
    dut_e (.clk(clk), .reset(rst_d), .d(d_d), .q(q_e));

  // One rising edge, then settle so inputs/outputs are away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    d_a = '0; d_b = '0; d_c = '0; d_d = '0;
    step();
    checks++;
    if (q_a !== 33'h0) begin errors++; $display("FAIL reset_a q=%h exp=%h", q_a, 33'h0); end
    checks++;
    if (q_b !== 8'hFF) begin errors++; $display("FAIL reset_b q=%h exp=%h", q_b, 8'hFF); end
    checks++;
    if (q_c !== 4'h0) begin errors++; $display("FAIL reset_c q=%h exp=%h", q_c, 4'h0); end
    checks++;
    if (q_d !== 16'h0 || q_e !== 16'h0) begin
      errors++; $display("FAIL reset_de q_d=%h q_e=%h exp=0000", q_d, q_e);
    end
  endtask

  // Plan 1: reset held with all-ones input, then release.
  task automatic test_release();
    rst_a = 1'b1;
    d_a   = 33'h1_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (q_a !== 33'h0) begin errors++; $display("FAIL release_hold[%0d] q=%h exp=%h", i, q_a, 33'h0); end
    end
    rst_a = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (i < 3) begin
        if (q_a !== 33'h0) begin errors++; $display("FAIL release_edge%0d q=%h exp=%h", i, q_a, 33'h0); end
      end else begin
        if (q_a !== 33'h1_FFFF_FFFF) begin
          errors++; $display("FAIL release_edge%0d q=%h exp=%h", i, q_a, 33'h1_FFFF_FFFF);
        end
      end
    end
  endtask

  // Plan 2: one-cycle pulse travels through and comes back out for one cycle.
  task automatic test_pulse();
    logic [32:0] exp_q [0:4];
    d_a = '0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (q_a !== 33'h0) begin errors++; $display("FAIL pulse_settle q=%h exp=%h", q_a, 33'h0); end
    d_a = 33'h0_1234_5678;
    step();                 // sampling edge (edge 1)
    d_a = '0;
    exp_q[0] = 33'h0;       // after edge 2
    exp_q[1] = 33'h0_1234_5678; // after edge 3
    exp_q[2] = 33'h0;
    exp_q[3] = 33'h0;
    exp_q[4] = 33'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (q_a !== exp_q[i]) begin errors++; $display("FAIL pulse_edge%0d q=%h exp=%h", i + 2, q_a, exp_q[i]); end
    end
  endtask

  // Plan 3: reset right after a sample flushes it; no ones leak out.
  task automatic test_reset_mid_flight();
    d_a = '0;
    for (int i = 0; i < 3; i++) step();
    d_a = 33'h1_FFFF_FFFF;
    step();                 // ones sampled into stage 0
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (q_a !== 33'h0) begin errors++; $display("FAIL midrst_hold[%0d] q=%h exp=%h", i, q_a, 33'h0); end
    end
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (i < 3) begin
        if (q_a !== 33'h0) begin errors++; $display("FAIL midrst_edge%0d q=%h exp=%h", i, q_a, 33'h0); end
      end else begin
        if (q_a !== 33'h1_FFFF_FFFF) begin
          errors++; $display("FAIL midrst_edge%0d q=%h exp=%h", i, q_a, 33'h1_FFFF_FFFF);
        end
      end
    end
  endtask

  // Plan 4: INIT_VALUE=1 drives all ones during reset, data after 2 edges.
  task automatic test_init_one();
    rst_b = 1'b1;
    d_b   = 8'h00;
    step(); step();
    checks++;
    if (q_b !== 8'hFF) begin errors++; $display("FAIL init1_hold q=%h exp=%h", q_b, 8'hFF); end
    rst_b = 1'b0;
    step();
    checks++;
    if (q_b !== 8'hFF) begin errors++; $display("FAIL init1_edge1 q=%h exp=%h", q_b, 8'hFF); end
    step();
    checks++;
    if (q_b !== 8'h00) begin errors++; $display("FAIL init1_edge2 q=%h exp=%h", q_b, 8'h00); end
  endtask

  // Plan 5: requested length 1 still gives two edges of latency.
  task automatic test_clamp();
    rst_c = 1'b1;
    d_c   = 4'h0;
    step();
    rst_c = 1'b0;
    step(); step();
    checks++;
    if (q_c !== 4'h0) begin errors++; $display("FAIL clamp_settle q=%h exp=%h", q_c, 4'h0); end
    d_c = 4'hA;
    step();
    checks++;
    if (q_c !== 4'h0) begin errors++; $display("FAIL clamp_edge1 q=%h exp=%h", q_c, 4'h0); end
    step();
    checks++;
    if (q_c !== 4'hA) begin errors++; $display("FAIL clamp_edge2 q=%h exp=%h", q_c, 4'hA); end
  endtask

  // Plan 6: both attribute flavours on one random stream; q is d four edges late.
  task automatic test_no_cut_equiv();
    logic [15:0] applied [$];
    logic [15:0] exp_q;
    rst_d = 1'b1;
    d_d   = '0;
    step();
    rst_d = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      d_d = 16'($urandom);
      applied.push_back(d_d);
      step();
      exp_q = (applied.size() >= 4) ? applied[applied.size() - 4] : 16'h0;
      checks++;
      if (q_d !== q_e) begin errors++; $display("FAIL nocut_equal[%0d] q_cut1=%h q_cut0=%h", n, q_d, q_e); end
      checks++;
      if (q_d !== exp_q) begin errors++; $display("FAIL nocut_delay[%0d] q=%h exp=%h", n, q_d, exp_q); end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_pulse();
    test_reset_mid_flight();
    test_init_one();
    test_clamp();
    test_no_cut_equiv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
